uart_tx: RTL
============

# uart_tx

Byte-serial UART transmitter for the flight-controller telemetry path. It consumes one ASCII byte at a time from the formatting stage (`tx_data`/`tx_valid`) and drives the 8N1 serial line, optionally 8E1. `tx_done` is the level "ready for next byte" flag that the formatting stage polls before issuing each byte.

## Interface
- `CLK_FREQ_HZ`, 100_000_000: system clock frequency.
- `BAUD`, 115_200: line rate. `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD`, truncating integer division (868 at defaults). `CLKS_PER_BIT < 2` is an elaboration error.

- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to send; sampled only on the accept edge.
- `tx_valid`  in  1  request; a one-cycle pulse is sufficient.
- `tx_done`  out  1  high = idle and ready to accept a byte; low while a frame is in flight.
- `uart_txd`  out  1  serial line, idle high.

## Operation
- Reset values: `uart_txd`=1, `tx_done`=1, state IDLE, counters 0.
- Accept rule:
  - A byte is accepted on a rising edge where `tx_valid && tx_done`.
  - `tx_data` is latched into the shift register on that edge.
  - `tx_done` goes low on that same edge.
- `tx_valid` while `tx_done`=0 is ignored. There is no buffering and no error flag.
- States:
  - IDLE: `uart_txd`=1. Go to START on accept.
  - START: `uart_txd`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A bit index 0..7 advances at each bit-period end. After bit 7, go to PARITY if enabled, else STOP.
  - PARITY: even-parity bit (XOR of the latched byte), held CLKS_PER_BIT cycles, then STOP.
  - STOP: `uart_txd`=1 for CLKS_PER_BIT cycles, then IDLE with `tx_done`=1.
- Bit-period counter:
  - Counts 0..CLKS_PER_BIT-1 and reloads to 0 on every state transition.
  - Width is `$clog2(CLKS_PER_BIT)`.
- `uart_txd` is driven from a register only, with no combinational path to the pin.
- Reset mid-frame: `uart_txd` returns high and `tx_done` high asynchronously. The partial frame is abandoned.
- Back-to-back requests:
  - A request on the same edge `tx_done` rises is not accepted, because `tx_done` is still 0 before that edge.
  - The earliest acceptance is the following edge. This gives at least 1 idle-high cycle between frames.

## Timing
- Accept edge = T0. `uart_txd` falls at T0. The start-bit edge lags the accept by zero cycles.
- Data bit n occupies cycles T0+(1+n)·CLKS_PER_BIT … T0+(2+n)·CLKS_PER_BIT−1.
- `tx_done` rises at T0 + F·CLKS_PER_BIT, where F=10 (F=11 with parity).
- Throughput is one byte per F·CLKS_PER_BIT + 1 cycles.
- At defaults a 5-byte field takes ≈ 43.4 k cycles (434 µs).

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in, giving an 8E1 frame with F=11.
- Not defined:
  - The PARITY state and its XOR logic are absent, giving an 8N1 frame with F=10.
  - The state encoding must not reserve the PARITY code.

## Structure
- Shared package `uart_pkg`:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - `UART_DATA_BITS = 8` and `UART_IDLE_LEVEL = 1'b1`.
  - Function `clks_per_bit(freq, baud)`.
  - The future `uart_rx` reuses this package.
- One sub-module, `uart_baud_gen`:
  - Bit-period counter with synchronous `restart` input and one-cycle `bit_tick` output at count CLKS_PER_BIT−1.
  - Parameterised by CLKS_PER_BIT; uses the same clock and reset.
- The FSM, shift register and bit index live in `uart_tx`.

## Test plan
Bench uses CLK_FREQ_HZ=460_800, BAUD=115_200 (CLKS_PER_BIT=4).
- Reset: hold `reset_n`=0 → `uart_txd`=1, `tx_done`=1. Release, idle 20 cycles → both remain 1.
- Single byte: pulse `tx_valid` with `tx_data`=8'h35 ('5') → line reads 0,1,0,1,0,1,1,0,0,1 (start, LSB-first data, stop), each bit 4 cycles. `tx_done` low for exactly 40 cycles (44 with `UART_TX_PARITY_EN`; parity bit = 0 for 8'h35).
- Busy request: pulse `tx_valid` with 8'hFF at T0+10 during a frame of 8'h20 → ignored. The wire carries only 8'h20, and `tx_done` still rises at T0+40.
- Formatter-style sequence: send "123 |" (8'h31,8'h32,8'h33,8'h20,8'h7C), each byte issued on the first cycle `tx_done`=1 → decoded stream matches, with 1 idle cycle between frames.
- Reset mid-frame: assert `reset_n`=0 at T0+17 during a frame of 8'hA5 → `uart_txd`=1 and `tx_done`=1 immediately. After release, a new byte 8'h3C is transmitted correctly.
- Parity (`UART_TX_PARITY_EN`): send 8'h07 → parity bit 1. Send 8'h03 → parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and baud helper (UART_TX_PARITY_EN selects the state set)
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;
`endif

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with synchronous restart and end-of-period tick
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic bit_tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - byte-serial 8N1 UART transmitter; define UART_TX_PARITY_EN for an 8E1 frame
import uart_pkg::*;

module uart_tx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115_200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_done,
    output logic       uart_txd
);

    localparam int          CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam logic [2:0]  LAST_BIT     = 3'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cfg
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end

    uart_state_e                 state_q, state_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic [2:0]                  bit_idx_q, bit_idx_d;
    logic                        txd_q, txd_d;
    logic                        done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                        parity_q, parity_d;
`endif

    logic bit_tick;

    // Holding the counter in restart while idle puts it at 0 on the accept edge;
    // every later transition lands on a tick, where the counter wraps to 0 itself.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (state_q == ST_IDLE),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        txd_d     = txd_q;
        done_d    = done_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                txd_d  = UART_IDLE_LEVEL;
                done_d = 1'b1;
                if (tx_valid && done_q) begin
                    shift_d   = tx_data;
                    bit_idx_d = '0;
                    txd_d     = 1'b0;
                    done_d    = 1'b0;
                    state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^tx_data;
`endif
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    txd_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = parity_q;
                        state_d = ST_PARITY;
`else
                        txd_d   = UART_IDLE_LEVEL;
                        state_d = ST_STOP;
`endif
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    txd_d   = UART_IDLE_LEVEL;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    txd_d   = UART_IDLE_LEVEL;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                txd_d   = UART_IDLE_LEVEL;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            txd_q     <= UART_IDLE_LEVEL;
            done_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign uart_txd = txd_q;
    assign tx_done  = done_q;

endmodule
